// File: rtl/score_display_scan.sv
// score_display_scan: round-robin double-dabble conversion of N_CH binary values
// into registered seven-segment digits with overflow dashes, zero blanking and blink.
module score_display_scan #(
  parameter int N_CH = 3,
  parameter int IN_W = 7,
  parameter int DIGITS = 2,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*IN_W-1:0]     val,
  input  logic                     blank_lz,
  input  logic [N_CH-1:0]          blink_en,
  input  logic                     blink_tick,
  output logic [N_CH*DIGITS*7-1:0] seg,
  output logic                     frame_done
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int KW = $clog2(IN_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam int FW = 7 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7f : 7'h00;
  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_STORE} state_t;
  state_t state, state_n;
  logic [CW-1:0] ch;
  logic [IN_W-1:0] shreg;
  logic [BW-1:0] bcd, adj;
  logic [KW-1:0] cnt;
  logic ovf, phase, lead;
  logic [6:0] pat;
  logic [FW-1:0] enc;
  logic [N_CH*FW-1:0] seg_r;

  function automatic logic [6:0] digit7(input logic [3:0] n);
    case (n)
      4'd0: digit7 = 7'b1000000;
      4'd1: digit7 = 7'b1111001;
      4'd2: digit7 = 7'b0100100;
      4'd3: digit7 = 7'b0110000;
      4'd4: digit7 = 7'b0011001;
      4'd5: digit7 = 7'b0010010;
      4'd6: digit7 = 7'b0000010;
      4'd7: digit7 = 7'b1111000;
      4'd8: digit7 = 7'b0000000;
      4'd9: digit7 = 7'b0010000;
      default: digit7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_n = state == S_LOAD  ? S_SHIFT :
              state == S_STORE ? S_LOAD  :
              cnt == KW'(IN_W - 1) ? S_STORE : S_SHIFT;
  end

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      adj[d*4 +: 4] = bcd[d*4 +: 4] >= 4'd5 ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
  end

  // Walk from the top digit down; lead stays set only while every digit so far is zero.
  always_comb begin
    enc = '0;
    pat = '0;
    lead = blank_lz;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lead = lead && bcd[d*4 +: 4] == 4'd0 && d != 0;
      pat = ovf ? 7'b0111111 : lead ? 7'b1111111 : digit7(bcd[d*4 +: 4]);
      enc[d*7 +: 7] = ACTIVE_LOW ? pat : ~pat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      ch <= '0;
      shreg <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      phase <= 1'b0;
      frame_done <= 1'b0;
      seg_r <= {N_CH*DIGITS{BLANK}};
    end else begin
      state <= state_n;
      phase <= phase ^ blink_tick;
      frame_done <= state == S_STORE && ch == LAST;
      if (state == S_LOAD) begin
        shreg <= val[ch*IN_W +: IN_W];
        bcd <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (state == S_SHIFT) begin
        ovf <= ovf | adj[BW-1];
        bcd <= {adj[BW-2:0], shreg[IN_W-1]};
        shreg <= shreg << 1;
        cnt <= cnt + 1'b1;
      end else begin
        seg_r[ch*FW +: FW] <= enc;
        ch <= ch == LAST ? '0 : ch + 1'b1;
      end
    end
  end

  always_comb begin
    seg = seg_r;
    for (int c = 0; c < N_CH; c++)
      seg[c*FW +: FW] = phase && blink_en[c] ? {DIGITS{BLANK}} : seg_r[c*FW +: FW];
  end
endmodule
